scan_chain_ctrl: RTL and testbench
==================================

// Module: scan_chain_ctrl
// PURPOSE
//  Parametrised scan-chain master for test-chip configuration and readback over the host interface.
//  On a start pulse it serialises NUM_CH words of DATA_LEN bits onto NUM_CH scan-in lines, all sharing one slow scan clock.
//  It captures NUM_CH scan-out lines in parallel, issues a load strobe and then reports done.
//  Everything runs in the clki domain; the scan clock is a registered output, never used as a clock internally.
// PARAMETERS
//  DATA_LEN  12      bits per chain (>=1)
//  NUM_CH    1       number of parallel chains (>=1)
//  HALF_DIV  1000000 clki cycles per scan-clock half period (>=1); 100 MHz clki gives 50 Hz sc_clk
//  MSB_FIRST 0       0: word bit 0 shifted out first; 1: bit DATA_LEN-1 first
// PORTS
//  clki      in   1                  system clock, 100 MHz
//  rst       in   1                  synchronous reset, active high
//  start     in   1                  request one scan transaction; sampled only in IDLE
//  data_in   in   NUM_CH*DATA_LEN    words to send; channel c occupies [c*DATA_LEN +: DATA_LEN]
//  sc_sin    in   NUM_CH             scan-out lines from chip
//  sc_clk    out  1                  scan clock to chip
//  sc_sout   out  NUM_CH             scan-in lines to chip
//  sc_load   out  1                  load/latch strobe to chip
//  data_out  out  NUM_CH*DATA_LEN    captured words, same channel packing as data_in
//  busy      out  1                  transaction in progress
//  done      out  1                  one-cycle completion pulse
// BEHAVIOUR
//  - Reset values: every output is 0, including data_out; FSM is IDLE; all counters are 0.
//  - Reset wins over every other event and takes effect on the next clki edge, including mid-transaction.
//    On that edge sc_clk and sc_load drop to 0 and no done is issued.
//  - Tick: a counter runs 0..HALF_DIV-1 in SHIFT/LOAD. tick=1 when it equals HALF_DIV-1, then it wraps to 0. It is cleared on every state entry.
//  - FSM IDLE->SHIFT->LOAD->DONE->IDLE.
//  - IDLE: sc_clk=0, busy=0. When start=1, latch data_in into the shift registers, drive the first bit on sc_sout and enter SHIFT with busy=1.
//  - SHIFT, low phase (sc_clk=0): on tick, sc_clk goes 1 and bit_cnt increments. The chip samples sc_sout on this rising edge.
//  - SHIFT, high phase (sc_clk=1): on tick, sc_clk goes 0 and each channel's sc_sin is shifted into its capture register with {cap[DATA_LEN-2:0], sc_sin[c]}.
//    - If bit_cnt==DATA_LEN, enter LOAD; sc_sout holds its last bit.
//    - Otherwise drive the next bit on sc_sout, on the same edge as the falling sc_clk.
//  - LOAD: sc_load=1 and sc_clk=0 for exactly 2*HALF_DIV cycles, then enter DONE.
//  - DONE: lasts one cycle. sc_load=0, done=1, data_out<=capture registers, busy drops to 0 on the next edge, return to IDLE.
//  - Latency: done is high exactly 2*HALF_DIV*(DATA_LEN+1)+2 clki edges after the edge that samples start.
//  - Sequence per transaction: DATA_LEN rising edges on sc_clk, one sc_load pulse, one done pulse.
//  - start while busy is ignored; it is neither queued nor able to restart.
//  - start on the same cycle as done is ignored. start is accepted again from the first IDLE cycle.
//  - data_in changing while busy has no effect; it is latched only at start.
//  - data_out holds its value until the next done or reset.
//  - sc_sout holds its last value in IDLE. After reset it is 0.
//  - Counter widths:
//    - tick counter: $clog2(HALF_DIV+1).
//    - bit_cnt: $clog2(DATA_LEN+1), which cannot overflow because it saturates at DATA_LEN.
// STRUCTURE
//  - Shared package scan_pkg: FSM state encoding (IDLE, SHIFT, LOAD, DONE as 2-bit localparams) and a clog2 helper constant function.
//  - One sub-module, scan_lane, generated NUM_CH times.
//    - Contents: one DATA_LEN shift register plus one capture register.
//    - Inputs: load, shift_next, capture, MSB_FIRST.
//    - Output: its sc_sout bit.
//  - The top level holds the FSM, tick counter, bit counter, and the sc_clk/sc_load registers.
// TESTING
//  - HALF_DIV=2, DATA_LEN=12, NUM_CH=1. data_in=12'hA5C, chip model loops sc_sout to sc_sin.
//    Expect: 12 sc_clk rises, sc_sout sequence LSB-first 0,0,1,1,1,0,1,0,0,1,0,1, done at edge 54.
//    Expect data_out = bit-reversed 12'h3A5 (first captured bit lands in MSB).
//  - MSB_FIRST=1, NUM_CH=3, each chip lane a 12-bit shift-register model preloaded with 12'h001, 12'h800, 12'hFFF.
//    Expect: data_out words equal the preloads; each lane's model finally holds its data_in word.
//  - Assert rst in the middle of SHIFT (after the 5th rise).
//    Expect: next edge sc_clk=0, busy=0, done never pulses. A fresh start then completes normally with correct data.
//  - start held high continuously for 3 transactions.
//    Expect: exactly 3 done pulses spaced 2*HALF_DIV*(DATA_LEN+1)+3 edges apart; start during busy has no effect.
//  - HALF_DIV=1, DATA_LEN=1 corner: sc_clk toggles every clki edge, one rise, sc_load high 2 cycles, done at edge 6.
//  - Assertions:
//    - sc_sout changes only when sc_clk falls, or on the entry edge into SHIFT.
//    - sc_load and sc_clk are never both 1.
//    - done implies the previous state was LOAD.

Source files
------------

// File: rtl/scan_pkg.sv
// Shared definitions for the scan-chain master: FSM encoding and a width helper.
package scan_pkg;

  // FSM state encoding, kept as plain 2-bit constants for legacy tool flows.
  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StShift = 2'd1;
  localparam logic [1:0] StLoad  = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  // Ceiling log2. It never returns 0, so the result is always usable as a vector width.
  function automatic int unsigned clog2_f(input int unsigned value);
    int unsigned res;
    res = 0;
    for (longint unsigned v = 1; v < longint'(value); v = v << 1) begin
      res++;
    end
    return (res == 0) ? 1 : res;
  endfunction

endpackage

// File: rtl/scan_lane.sv
// One scan channel: a parallel-load shift register that drives scan-in, plus a capture register
// that collects the chip's scan-out.
module scan_lane
  import scan_pkg::*;
#(
  parameter int unsigned DATA_LEN  = 12,
  parameter bit          MSB_FIRST = 1'b0
) (
  input  logic                clki,
  input  logic                rst,
  input  logic                load,
  input  logic                shift_next,
  input  logic                capture,
  input  logic [DATA_LEN-1:0] load_data,
  input  logic                sin,
  output logic                sout,
  output logic [DATA_LEN-1:0] cap_data
);

  logic [DATA_LEN-1:0] sreg_q, sreg_d;
  logic [DATA_LEN-1:0] cap_q, cap_d;

  // Next-state for the shift and capture registers.
  always_comb begin
    sreg_d = sreg_q;
    cap_d  = cap_q;
    if (load) begin
      sreg_d = load_data;
    end else if (shift_next) begin
      sreg_d = MSB_FIRST ? (sreg_q << 1) : (sreg_q >> 1);
    end
    // The first captured bit migrates up to the MSB after DATA_LEN captures.
    if (capture) begin
      cap_d = (cap_q << 1) | DATA_LEN'(sin);
    end
  end

  // Register state with synchronous reset.
  always_ff @(posedge clki) begin
    if (rst) begin
      sreg_q <= '0;
      cap_q  <= '0;
    end else begin
      sreg_q <= sreg_d;
      cap_q  <= cap_d;
    end
  end

  // The outgoing bit comes straight from a flop, so it holds its value while idle.
  assign sout     = MSB_FIRST ? sreg_q[DATA_LEN-1] : sreg_q[0];
  assign cap_data = cap_q;

endmodule

// File: rtl/scan_chain_ctrl.sv
// Scan-chain master: serialises NUM_CH words onto parallel scan-in lines under one divided scan
// clock, captures the scan-out lines, strobes load and reports done.
module scan_chain_ctrl
  import scan_pkg::*;
#(
  parameter int unsigned DATA_LEN  = 12,
  parameter int unsigned NUM_CH    = 1,
  parameter int unsigned HALF_DIV  = 1000000,
  parameter bit          MSB_FIRST = 1'b0
) (
  input  logic                       clki,
  input  logic                       rst,
  input  logic                       start,
  input  logic [NUM_CH*DATA_LEN-1:0] data_in,
  input  logic [NUM_CH-1:0]          sc_sin,
  output logic                       sc_clk,
  output logic [NUM_CH-1:0]          sc_sout,
  output logic                       sc_load,
  output logic [NUM_CH*DATA_LEN-1:0] data_out,
  output logic                       busy,
  output logic                       done
);

  localparam int unsigned TickW = clog2_f(HALF_DIV + 1);
  localparam int unsigned BitW  = clog2_f(DATA_LEN + 1);
  localparam logic [TickW-1:0] TickMax = TickW'(HALF_DIV - 1);
  localparam logic [BitW-1:0]  BitMax  = BitW'(DATA_LEN);

  logic [1:0]                 state_q, state_d;
  logic [TickW-1:0]           tick_cnt_q, tick_cnt_d;
  logic [BitW-1:0]            bit_cnt_q, bit_cnt_d;
  logic                       sc_clk_q, sc_clk_d;
  logic                       sc_load_q, sc_load_d;
  logic                       load_half_q, load_half_d;
  logic [NUM_CH*DATA_LEN-1:0] data_out_q, data_out_d;
  logic [NUM_CH*DATA_LEN-1:0] cap_all;

  logic tick;
  logic lane_load, lane_shift, lane_capture;

  assign tick = (tick_cnt_q == TickMax);

  // Lane controls: load on accepted start, capture on every falling sc_clk, advance on every
  // falling sc_clk except the last so the final bit stays on the line.
  always_comb begin
    lane_load    = (state_q == StIdle) && start;
    lane_capture = (state_q == StShift) && sc_clk_q && tick;
    lane_shift   = lane_capture && (bit_cnt_q != BitMax);
  end

  // FSM, tick divider, bit counter and scan-clock / load-strobe next-state.
  always_comb begin
    state_d     = state_q;
    tick_cnt_d  = tick_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    sc_clk_d    = sc_clk_q;
    sc_load_d   = sc_load_q;
    load_half_d = load_half_q;
    data_out_d  = data_out_q;
    unique case (state_q)
      StIdle: begin
        sc_clk_d  = 1'b0;
        sc_load_d = 1'b0;
        if (start) begin
          state_d    = StShift;
          tick_cnt_d = '0;
          bit_cnt_d  = '0;
        end
      end
      StShift: begin
        if (tick) begin
          tick_cnt_d = '0;
          if (!sc_clk_q) begin
            sc_clk_d = 1'b1;
            if (bit_cnt_q != BitMax) begin
              bit_cnt_d = bit_cnt_q + BitW'(1);
            end
          end else begin
            sc_clk_d = 1'b0;
            if (bit_cnt_q == BitMax) begin
              state_d     = StLoad;
              load_half_d = 1'b0;
            end
          end
        end else begin
          tick_cnt_d = tick_cnt_q + TickW'(1);
        end
      end
      StLoad: begin
        // One setup cycle after sc_clk falls, then sc_load is held for two tick periods.
        if (!sc_load_q) begin
          sc_load_d  = 1'b1;
          tick_cnt_d = '0;
        end else if (tick) begin
          tick_cnt_d = '0;
          if (load_half_q) begin
            state_d   = StDone;
            sc_load_d = 1'b0;
          end else begin
            load_half_d = 1'b1;
          end
        end else begin
          tick_cnt_d = tick_cnt_q + TickW'(1);
        end
      end
      StDone: begin
        state_d    = StIdle;
        data_out_d = cap_all;
      end
    endcase
  end

  // State registers with synchronous reset that overrides everything.
  always_ff @(posedge clki) begin
    if (rst) begin
      state_q     <= StIdle;
      tick_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      sc_clk_q    <= 1'b0;
      sc_load_q   <= 1'b0;
      load_half_q <= 1'b0;
      data_out_q  <= '0;
    end else begin
      state_q     <= state_d;
      tick_cnt_q  <= tick_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      sc_clk_q    <= sc_clk_d;
      sc_load_q   <= sc_load_d;
      load_half_q <= load_half_d;
      data_out_q  <= data_out_d;
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
    scan_lane #(
      .DATA_LEN (DATA_LEN),
      .MSB_FIRST(MSB_FIRST)
    ) u_lane (
      .clki      (clki),
      .rst       (rst),
      .load      (lane_load),
      .shift_next(lane_shift),
      .capture   (lane_capture),
      .load_data (data_in[c*DATA_LEN +: DATA_LEN]),
      .sin       (sc_sin[c]),
      .sout      (sc_sout[c]),
      .cap_data  (cap_all[c*DATA_LEN +: DATA_LEN])
    );
  end

  assign sc_clk   = sc_clk_q;
  assign sc_load  = sc_load_q;
  assign data_out = data_out_q;
  assign busy     = (state_q != StIdle);
  assign done     = (state_q == StDone);

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Self-checking bench for scan_chain_ctrl: loopback, multi-lane chip model, reset abort,
// back-to-back starts and the minimum-size corner.
module tb_scan_chain_ctrl;

  // Edge (counted from the start-sampling edge 0) whose sampling sees done high.
  localparam int Lat0 = 2 * 2 * (12 + 1) + 2;   // 54
  localparam int Gap0 = 2 * 2 * (12 + 1) + 3;   // 55

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Instance 0: HALF_DIV=2, DATA_LEN=12, one lane, LSB first, loopback chip.
  logic        start0 = 1'b0;
  logic [11:0] data_in0 = '0;
  logic        sc_clk0, sc_load0, busy0, done0;
  logic [0:0]  sc_sout0, sc_sin0;
  logic [11:0] data_out0;
  assign sc_sin0 = sc_sout0;

  scan_chain_ctrl #(
    .DATA_LEN(12), .NUM_CH(1), .HALF_DIV(2), .MSB_FIRST(1'b0)
  ) u0 (
    .clki(clk), .rst(rst), .start(start0), .data_in(data_in0), .sc_sin(sc_sin0),
    .sc_clk(sc_clk0), .sc_sout(sc_sout0), .sc_load(sc_load0), .data_out(data_out0),
    .busy(busy0), .done(done0)
  );

  // Instance 1: three lanes, MSB first, each chip lane a 12-bit shift register.
  logic        start1 = 1'b0;
  logic [35:0] data_in1 = '0;
  logic        sc_clk1, sc_load1, busy1, done1;
  logic [2:0]  sc_sout1, sc_sin1;
  logic [35:0] data_out1;
  logic [11:0] mdl [3];
  logic [2:0]  mdl_out;
  logic        mdl_ld = 1'b0;
  logic [35:0] pre_v = {12'hFFF, 12'h800, 12'h001};
  assign sc_sin1 = mdl_out;

  scan_chain_ctrl #(
    .DATA_LEN(12), .NUM_CH(3), .HALF_DIV(2), .MSB_FIRST(1'b1)
  ) u1 (
    .clki(clk), .rst(rst), .start(start1), .data_in(data_in1), .sc_sin(sc_sin1),
    .sc_clk(sc_clk1), .sc_sout(sc_sout1), .sc_load(sc_load1), .data_out(data_out1),
    .busy(busy1), .done(done1)
  );

  // Chip model: samples scan-in on rising sc_clk and presents the bit it shifted out.
  always @(posedge sc_clk1 or posedge mdl_ld) begin
    if (mdl_ld) begin
      for (int c = 0; c < 3; c++) mdl[c] <= pre_v[c*12 +: 12];
      mdl_out <= '0;
    end else begin
      for (int c = 0; c < 3; c++) begin
        mdl_out[c] <= mdl[c][11];
        mdl[c]     <= {mdl[c][10:0], sc_sout1[c]};
      end
    end
  end

  // Instance 2: HALF_DIV=1, DATA_LEN=1 corner, loopback.
  logic       start2 = 1'b0;
  logic [0:0] data_in2 = '0;
  logic       sc_clk2, sc_load2, busy2, done2;
  logic [0:0] sc_sout2, sc_sin2, data_out2;
  assign sc_sin2 = sc_sout2;

  scan_chain_ctrl #(
    .DATA_LEN(1), .NUM_CH(1), .HALF_DIV(1), .MSB_FIRST(1'b0)
  ) u2 (
    .clki(clk), .rst(rst), .start(start2), .data_in(data_in2), .sc_sin(sc_sin2),
    .sc_clk(sc_clk2), .sc_sout(sc_sout2), .sc_load(sc_load2), .data_out(data_out2),
    .busy(busy2), .done(done2)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Protocol invariants, sampled 1 time unit after every clock edge.
  logic mon_en = 1'b0;
  logic p_clk0 = 1'b0, p_sout0 = 1'b0, p_busy0 = 1'b0, p_load0 = 1'b0;
  logic p_load1 = 1'b0, p_load2 = 1'b0;
  always @(posedge clk) begin
    logic r;
    r = rst;
    #1;
    if (mon_en) begin
      if ((sc_load0 && sc_clk0) || (sc_load1 && sc_clk1) || (sc_load2 && sc_clk2)) begin
        fails++;
        $display("FAIL load_clk_overlap: got sc_load=sc_clk=1, expected never both");
      end
      if (sc_sout0[0] !== p_sout0 && !(p_clk0 && !sc_clk0) && !(!p_busy0 && busy0) && !r) begin
        fails++;
        $display("FAIL sout_timing: got change %0b->%0b outside sc_clk fall, expected none",
                 p_sout0, sc_sout0[0]);
      end
      if ((done0 && !p_load0) || (done1 && !p_load1) || (done2 && !p_load2)) begin
        fails++;
        $display("FAIL done_after_load: got done without prior LOAD, expected LOAD first");
      end
    end
    p_clk0  = sc_clk0;
    p_sout0 = sc_sout0[0];
    p_busy0 = busy0;
    p_load0 = sc_load0;
    p_load1 = sc_load1;
    p_load2 = sc_load2;
  end

  typedef struct {
    logic [11:0] din;
    logic [11:0] dout;
  } vec_t;
  vec_t vecs [6];

  typedef struct {
    logic clk_e;
    logic load_e;
    logic done_e;
  } step_t;
  step_t steps [5];

  // One loopback transaction on u0; data_in is scrambled while busy to show it is ignored.
  task automatic run_u0(input logic [11:0] din, input logic [11:0] exp);
    int          rises;
    int          done_edge;
    logic [11:0] souts;
    logic        prev_clk;
    rises     = 0;
    done_edge = -1;
    souts     = '0;
    data_in0  = din;
    start0    = 1'b1;
    @(posedge clk);
    #1;
    start0   = 1'b0;
    data_in0 = ~din;
    check("busy_after_start", 64'(busy0), 64'd1);
    prev_clk = sc_clk0;
    for (int e = 1; e <= 200; e++) begin
      @(posedge clk);
      #1;
      if (sc_clk0 && !prev_clk) begin
        if (rises < 12) souts[rises] = sc_sout0[0];
        rises++;
      end
      prev_clk = sc_clk0;
      if (done0) begin
        done_edge = e + 1;
        break;
      end
    end
    check("rise_count", 64'(rises), 64'd12);
    check("done_latency", 64'(done_edge), 64'(Lat0));
    check("sout_sequence", 64'(souts), 64'(din));
    @(posedge clk);
    #1;
    check("data_out", 64'(data_out0), 64'(exp));
    check("busy_cleared", 64'(busy0), 64'd0);
  endtask

  initial begin
    int rises;
    int dcount;
    int dpos [3];

    vecs[0] = '{din: 12'hA5C, dout: 12'h3A5};
    vecs[1] = '{din: 12'h000, dout: 12'h000};
    vecs[2] = '{din: 12'hFFF, dout: 12'hFFF};
    vecs[3] = '{din: 12'h001, dout: 12'h800};
    vecs[4] = '{din: 12'h800, dout: 12'h001};
    vecs[5] = '{din: 12'h0F0, dout: 12'h0F0};

    steps[0] = '{clk_e: 1'b1, load_e: 1'b0, done_e: 1'b0};
    steps[1] = '{clk_e: 1'b0, load_e: 1'b0, done_e: 1'b0};
    steps[2] = '{clk_e: 1'b0, load_e: 1'b1, done_e: 1'b0};
    steps[3] = '{clk_e: 1'b0, load_e: 1'b1, done_e: 1'b0};
    steps[4] = '{clk_e: 1'b0, load_e: 1'b0, done_e: 1'b1};

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_sc_clk", 64'(sc_clk0), 64'd0);
    check("reset_sc_sout", 64'(sc_sout0), 64'd0);
    check("reset_sc_load", 64'(sc_load0), 64'd0);
    check("reset_busy_done", 64'({busy0, done0}), 64'd0);
    check("reset_data_out", 64'(data_out0), 64'd0);
    mon_en = 1'b1;

    // Table-driven loopback transactions.
    for (int i = 0; i < 6; i++) run_u0(vecs[i].din, vecs[i].dout);
    check("sout_holds_idle", 64'(sc_sout0), 64'(vecs[5].din[11]));

    // Reset in the middle of SHIFT, after the fifth rise.
    data_in0 = 12'hA5C;
    start0   = 1'b1;
    @(posedge clk);
    #1;
    start0 = 1'b0;
    rises  = 0;
    for (int e = 0; e < 100 && rises < 5; e++) begin
      @(posedge clk);
      #1;
      if (sc_clk0 && !p_clk0) rises++;
    end
    check("rises_before_reset", 64'(rises), 64'd5);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("abort_sc_clk", 64'(sc_clk0), 64'd0);
    check("abort_busy", 64'(busy0), 64'd0);
    check("abort_sc_load", 64'(sc_load0), 64'd0);
    dcount = 0;
    for (int e = 0; e < 80; e++) begin
      @(posedge clk);
      #1;
      if (done0) dcount++;
    end
    check("abort_no_done", 64'(dcount), 64'd0);
    run_u0(12'h5A3, 12'hC5A);

    // start held high across three transactions.
    dcount   = 0;
    data_in0 = 12'h3C6;
    start0   = 1'b1;
    @(posedge clk);
    #1;
    for (int e = 1; e <= 200; e++) begin
      @(posedge clk);
      #1;
      if (done0) begin
        if (dcount < 3) dpos[dcount] = e + 1;
        dcount++;
      end
      if (e == Lat0 - 1 + 1) check("idle_after_done", 64'(busy0), 64'd0);
      if (e == Lat0 + 1) check("restart_from_idle", 64'(busy0), 64'd1);
      if (e == Lat0 - 1 + 2 * Gap0) start0 = 1'b0;
    end
    check("held_done_count", 64'(dcount), 64'd3);
    check("held_done_0", 64'(dpos[0]), 64'(Lat0));
    check("held_done_1", 64'(dpos[1] - dpos[0]), 64'(Gap0));
    check("held_done_2", 64'(dpos[2] - dpos[1]), 64'(Gap0));
    check("held_final_idle", 64'(busy0), 64'd0);
    check("held_data_out", 64'(data_out0), 64'h63C);

    // Three-lane MSB-first transaction against the chip model.
    mdl_ld = 1'b1;
    #1;
    mdl_ld   = 1'b0;
    data_in1 = {12'h5E7, 12'hABC, 12'h123};
    start1   = 1'b1;
    @(posedge clk);
    #1;
    start1 = 1'b0;
    dcount = -1;
    for (int e = 1; e <= 200; e++) begin
      @(posedge clk);
      #1;
      if (done1) begin
        dcount = e + 1;
        break;
      end
    end
    check("lanes_done_latency", 64'(dcount), 64'(Lat0));
    @(posedge clk);
    #1;
    check("lane0_data_out", 64'(data_out1[11:0]), 64'h001);
    check("lane1_data_out", 64'(data_out1[23:12]), 64'h800);
    check("lane2_data_out", 64'(data_out1[35:24]), 64'hFFF);
    check("lane0_chip", 64'(mdl[0]), 64'h123);
    check("lane1_chip", 64'(mdl[1]), 64'hABC);
    check("lane2_chip", 64'(mdl[2]), 64'h5E7);

    // HALF_DIV=1, DATA_LEN=1 corner, checked edge by edge.
    data_in2 = 1'b1;
    start2   = 1'b1;
    @(posedge clk);
    #1;
    start2 = 1'b0;
    for (int e = 0; e < 5; e++) begin
      @(posedge clk);
      #1;
      check($sformatf("corner_e%0d", e + 1), 64'({sc_clk2, sc_load2, done2}),
            64'({steps[e].clk_e, steps[e].load_e, steps[e].done_e}));
    end
    @(posedge clk);
    #1;
    check("corner_data_out", 64'(data_out2), 64'd1);
    check("corner_busy", 64'(busy2), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
